// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame, device ACK check.
// Optional retry on NACK/timeout when PS2_TX_RETRY_EN is defined.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES       = 6500,
    parameter int START_TIMEOUT_CYCLES = 975000,
    parameter int FRAME_TIMEOUT_CYCLES = 130000,
    parameter int MAX_RETRIES          = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int MAX_A = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ? INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
    localparam int MAX_P = (MAX_A > FRAME_TIMEOUT_CYCLES) ? MAX_A : FRAME_TIMEOUT_CYCLES;
    localparam int CW    = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};
    localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] FRM_LAST   = CW'(FRAME_TIMEOUT_CYCLES - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] INHIBIT   = 3'd1;
    localparam logic [2:0] RTS       = 3'd2;
    localparam logic [2:0] SHIFT     = 3'd3;
    localparam logic [2:0] ACK       = 3'd4;
    localparam logic [2:0] WAIT_IDLE = 3'd5;
    localparam logic [2:0] FAIL      = 3'd6;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [8:0]    shreg;
    logic          out_bit;
    logic          clk_s1, clk_s2, clk_s3, dat_s1, dat_s2;
    logic          fe;
    logic          retry_ok;

    // Synchronizers reset to the idle-high line level so reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_s3 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk_in;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            dat_s1 <= ps2_data_in;
            dat_s2 <= dat_s1;
        end
    end

    assign fe = clk_s3 & ~clk_s2;

`ifdef PS2_TX_RETRY_EN
    localparam int RW = $clog2(MAX_RETRIES + 2);
    logic [RW-1:0] retry_cnt;

    assign retry_ok = (int'(retry_cnt) < MAX_RETRIES);

    always_ff @(posedge clk) begin
        if (!rst)
            retry_cnt <= '0;
        else if (state == IDLE && tx_valid)
            retry_cnt <= '0;
        else if (state == FAIL && retry_ok)
            retry_cnt <= retry_cnt + RW'(1);
    end
`else
    assign retry_ok = 1'b0 & (MAX_RETRIES > 0);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            out_bit <= 1'b1;
        end else begin
            if (cnt != CNT_MAX)
                cnt <= cnt + CW'(1);
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (tx_valid) begin
                        state <= INHIBIT;
                        shreg <= {~^tx_data, tx_data};
                    end
                end
                INHIBIT: if (cnt >= INH_LAST) begin
                    state <= RTS;
                    cnt   <= '0;
                end
                RTS: begin
                    if (fe) begin
                        state   <= SHIFT;
                        cnt     <= '0;
                        bit_idx <= 4'd1;
                        out_bit <= shreg[0];
                    end else if (cnt >= START_LAST) begin
                        state <= FAIL;
                    end
                end
                // bit_idx counts edges already seen; edge 10 releases data for the stop bit.
                SHIFT: begin
                    if (cnt >= FRM_LAST)
                        state <= FAIL;
                    else if (fe) begin
                        if (bit_idx == 4'd9) begin
                            state   <= ACK;
                            out_bit <= 1'b1;
                        end else begin
                            out_bit <= shreg[bit_idx];
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                end
                ACK: begin
                    if (cnt >= FRM_LAST)
                        state <= FAIL;
                    else if (fe)
                        state <= dat_s2 ? FAIL : WAIT_IDLE;
                end
                WAIT_IDLE: begin
                    if (clk_s2 && dat_s2)
                        state <= IDLE;
                    else if (cnt >= FRM_LAST)
                        state <= FAIL;
                end
                FAIL: begin
                    cnt   <= '0;
                    state <= retry_ok ? INHIBIT : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tx_ready    = (state == IDLE);
    assign busy        = ~tx_ready;
    assign done        = (state == WAIT_IDLE) & clk_s2 & dat_s2;
    assign error       = (state == FAIL) & ~retry_ok;
    assign ps2_clk_oe  = (state == INHIBIT);
    assign ps2_data_oe = (state == RTS) | ((state == SHIFT) & ~out_bit);
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: the opposite direction of the existing mouse receive path.
- Sends one command byte to the mouse, e.g. 0xF4 enable reporting, 0xFF reset, 0xF3 set sample rate.
- Runs the full PS/2 host request-to-send sequence, then checks the device ACK.
- Sits beside the mouse controller in the input section. The top level merges the open-drain pull-downs into the ps2_clk/ps2_data inouts.

Parameters:
- INHIBIT_CYCLES, 6500: clock-inhibit hold time in clk cycles (100 us at 65 MHz).
- START_TIMEOUT_CYCLES, 975000: maximum wait from RTS to the first device clock falling edge (15 ms).
- FRAME_TIMEOUT_CYCLES, 130000: maximum time from the first falling edge to the ACK edge (2 ms).
- MAX_RETRIES, 2: extra attempts made after a failure; used only when PS2_TX_RETRY_EN is defined.

Ports:
- clk  in  1  system clock, 65 MHz
- rst  in  1  synchronous, active-low reset (0 = reset)
- tx_data  in  8  command byte
- tx_valid  in  1  byte offered
- tx_ready  out  1  block can accept a byte
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse: byte sent and ACKed
- error  out  1  one-cycle pulse: NACK or timeout
- ps2_clk_in  in  1  raw PS/2 clock line level
- ps2_data_in  in  1  raw PS/2 data line level
- ps2_clk_oe  out  1  1 = pull PS/2 clock low; 0 = release
- ps2_data_oe  out  1  1 = pull PS/2 data low; 0 = release

Behaviour:
- Input conditioning: ps2_clk_in and ps2_data_in each pass through a 2-FF synchronizer. A clock falling edge (fe) is detected on the synchronized clock with 1 extra cycle of latency.
- Handshake: tx_ready = (state == IDLE). A byte is accepted on the cycle with tx_valid && tx_ready. On acceptance the block latches tx_data and computes parity = ~^tx_data (odd parity). tx_valid is ignored while busy.
- busy = !tx_ready.
- Reset values: state IDLE; tx_ready 1; busy 0; done 0; error 0; both oe 0; all counters 0.
- States:
  - IDLE: both lines released. On accept -> INHIBIT, cycle counter cleared.
  - INHIBIT: clk_oe = 1 and data_oe = 0 for exactly INHIBIT_CYCLES cycles, then -> RTS.
  - RTS: data_oe = 1 (start bit 0); clk_oe = 0 from the first RTS cycle onward. The wait counter runs. First fe -> SHIFT with bit index 0. Counter reaching START_TIMEOUT_CYCLES -> FAIL.
  - SHIFT: frame counter runs. On each fe the host drives the next bit:
    - edges 1..8: d0..d7, LSB first;
    - edge 9: parity;
    - edge 10: release data (stop bit = 1).
    - Driving a bit means data_oe = ~bit.
    - After edge 10 -> ACK.
  - ACK: on fe 11, sample synchronized data. 0 -> WAIT_IDLE; 1 -> FAIL (NACK).
  - WAIT_IDLE: wait until synchronized clock and data are both 1, then pulse done for 1 cycle -> IDLE.
  - The frame timeout (FRAME_TIMEOUT_CYCLES since the first fe) applies in SHIFT, ACK and WAIT_IDLE -> FAIL.
  - FAIL: both oe 0; error pulses for 1 cycle -> IDLE.
- Edges outside RTS/SHIFT/ACK are ignored, including device or glitch edges during INHIBIT.
- Counters are $clog2(max parameter + 1) wide and saturate; they never wrap.
- done and error are never asserted in the same cycle.
- Reset during any state: on the next clk edge both oe = 0, state IDLE, and the partial frame is discarded with no done/error pulse.
- Latency: accept -> clk_oe high on the following cycle. Line changes follow fe detection by 1 cycle.

Optional Feature:
- Macro PS2_TX_RETRY_EN.
- Defined: FAIL does not return to IDLE while the retry count is below MAX_RETRIES. Instead it increments the count and re-enters INHIBIT with the latched byte. error pulses only after the final failed attempt. The retry count clears on accept.
- Undefined: no retry logic is synthesized and every failure pulses error immediately.

Test Plan:
- Send 0xF4. Device model clocks about 15 kHz and ACKs. Required:
  - bits seen at device rising edges = 0 (start), 0,0,1,0,1,1,1,1, parity 0, stop 1;
  - exactly one done pulse, no error;
  - tx_ready returns to 1.
- Inhibit timing, INHIBIT_CYCLES = 20:
  - clk_oe is 1 for exactly 20 cycles after accept;
  - then clk_oe = 0 and data_oe = 1.
- NACK: device leaves data high at edge 11 -> one error pulse, no done, both oe 0, state IDLE. With PS2_TX_RETRY_EN and MAX_RETRIES = 2: 3 full frames are observed before the single error pulse.
- Silent device, START_TIMEOUT_CYCLES = 100, no clock edges -> error pulses 100 cycles after RTS entry; data_oe returns to 0.
- Reset (rst = 0) asserted after edge 4 of sending 0xFF -> next cycle both oe 0, tx_ready 1, no done/error; a following 0xF4 transfer completes normally.
- tx_valid held high with 0xAA during a 0xF4 transfer -> only 0xF4 bits appear on the line; 0xAA is accepted only after done.
